// File: rtl/sp_inst_fetch.sv
// Instruction fetch/issue stage: walks the PC, prefetches into a small FIFO and streams words to the core.
// Optional SP_FETCH_PERF_EN adds stall_cnt / bp_cnt performance counters.
module sp_inst_fetch #(
  parameter int ADDR_W   = 12,
  parameter int DEPTH    = 4,
  parameter int EXEC_NUM = 3700
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_re,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              busy,
  output logic              done
`ifdef SP_FETCH_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bp_cnt
`endif
);

  // Sized so EXEC_NUM+1 fits, keeping accepted+pop free of wrap.
  localparam int CNT_W = $clog2(EXEC_NUM + 2);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 2;
  localparam logic [CNT_W-1:0] EXEC_LIM = CNT_W'(EXEC_NUM);
  localparam logic [OCC_W-1:0] DEPTH_LIM = OCC_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  pc;
  logic [CNT_W-1:0]   issued;
  logic [CNT_W-1:0]   accepted;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_pc;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic [31:0]        fifo_data [DEPTH];
  logic [ADDR_W-1:0]  fifo_pc   [DEPTH];

  logic               issue;
  logic               start_ok;
  logic               done_set;
  logic               push;
  logic               pop;
  logic [OCC_W-1:0]   occupancy;
  logic [CNT_W-1:0]   accepted_nxt;

  assign push         = inflight;
  assign pop          = inst_valid && inst_ready;
  assign occupancy    = OCC_W'(count) + OCC_W'(inflight);
  assign accepted_nxt = accepted + CNT_W'(pop);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    start_ok  = 1'b0;
    done_set  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (issued == EXEC_LIM) begin
          state_nxt = S_DRAIN;
        end else if (occupancy < DEPTH_LIM) begin
          issue = 1'b1;
        end
      end
      S_DRAIN: begin
        // Leave on the edge that accepts the final word so done follows it directly.
        if (accepted_nxt == EXEC_LIM) begin
          state_nxt = S_IDLE;
          done_set  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      issued      <= '0;
      accepted    <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      done        <= 1'b0;
    end else begin
      state    <= state_nxt;
      done     <= done_set;
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
      end
      if (start_ok) begin
        pc       <= '0;
        issued   <= '0;
        accepted <= '0;
      end else begin
        if (issue) begin
          pc     <= pc + ADDR_W'(1);
          issued <= issued + CNT_W'(1);
        end
        if (pop) begin
          accepted <= accepted_nxt;
        end
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; a read landing during rst is dropped here.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_data[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= inflight_pc;
    end
  end

  assign imem_re    = issue;
  assign imem_addr  = pc;
  assign inst_valid = (count != '0);
  assign inst_data  = inst_valid ? fifo_data[rd_ptr] : 32'd0;
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr] : '0;
  assign busy       = (state != S_IDLE);

`ifdef SP_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      stall_cnt <= '0;
      bp_cnt    <= '0;
    end else if (busy) begin
      if (!inst_valid) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (inst_valid && !inst_ready) begin
        bp_cnt <= bp_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
